cache_fill_arbiter: RTL and testbench
=====================================

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-004 dcache_miss  input  1  D-cache miss request, held high until serviced.
REQ-005 dcache_miss_addr  input  16  byte address of D-cache miss.
REQ-006 icache_miss  input  1  I-cache miss request, held high until serviced.
REQ-007 icache_miss_addr  input  16  byte address of I-cache miss.
REQ-008 memory_data_valid  input  1  main memory read data valid this cycle.
REQ-009 memory_data_out  input  16  main memory read data.
REQ-010 mem_addr  output  16  main memory read address.
REQ-011 mem_enable  output  1  main memory read request, one word per cycle.
REQ-012 fsm_busy  output  1  fill in progress.
REQ-013 fill_owner  output  1  1 = D-cache fill, 0 = I-cache fill; meaningful only while fsm_busy.
REQ-014 fill_data  output  16  word to write into the owner's data array (equals memory_data_out).
REQ-015 write_data_array  output  1  owner data array write strobe.
REQ-016 word_enable  output  8  one-hot word select within the 16-byte block.
REQ-017 write_tag_array  output  1  owner tag array write strobe (drives the cache's tag-write input).
REQ-018 fill_done_d / fill_done_i  output  1 each  one-cycle completion pulse per requester.

Function
REQ-019 The FSM SHALL have states IDLE, FILL, COMMIT.
REQ-020 In IDLE with any miss high, the FSM SHALL grant on the next edge, go to FILL, latch the owner, and latch the base address = miss_addr & 16'hFFF0.
REQ-021 Simultaneous misses SHALL grant D-cache (fixed priority); the I-cache request stays pending and is granted in the first IDLE cycle after the D-cache fill completes.
REQ-022 In FILL, the FSM SHALL assert mem_enable for exactly 8 consecutive cycles starting in the first FILL cycle, with mem_addr = base + 2*k, k = 0..7 (3-bit issue counter).
REQ-023 Each memory_data_valid in FILL SHALL assert write_data_array for that cycle, with word_enable = one-hot(receive counter), then increment the receive counter; returns fill words 0..7 in order.
REQ-024 The block SHALL be latency-agnostic: completion is driven by the count of memory_data_valid pulses, not by a fixed delay; with 4-cycle memory, the last word arrives in FILL cycle 11.
REQ-025 On the 8th valid, the FSM SHALL go to COMMIT; COMMIT lasts one cycle and asserts write_tag_array and the owner's fill_done pulse.
REQ-026 From COMMIT the FSM SHALL return to IDLE; re-arbitration occurs no earlier than that IDLE cycle.
REQ-027 memory_data_valid in IDLE or COMMIT SHALL be ignored (no strobes).
REQ-028 Deassertion of the owner's miss mid-fill SHALL NOT abort the fill; the block SHALL be completed and committed.
REQ-029 Address bits [3:0] of the miss SHALL NOT affect the fill; mem_addr never wraps past base+14.
REQ-030 All outputs other than fill_data SHALL be 0 when not asserted by the above rules; mem_addr SHALL be 0 when mem_enable is 0.

Reset
REQ-031 rst low SHALL force IDLE, clear both counters, base, and owner, and drive all outputs to 0 immediately, independent of clk.
REQ-032 Reset during FILL SHALL discard the fill with no write_tag_array or fill_done; later in-flight memory_data_valid returns SHALL be ignored per REQ-027.

Structure
REQ-033 State encoding, BLOCK_WORDS = 8, and WORD_BYTES = 2 SHALL live in the shared cache package, alongside the cache constants.
REQ-034 One sub-module, fill_counter (3-bit counter with clear, enable, and terminal-count output), SHALL be instantiated twice: once for issue, once for receive.

Verification
REQ-035 dcache_miss = 1, addr = 16'h1236, memory latency 4 -> mem_addr 1230, 1232, ..., 123E on 8 consecutive cycles; word_enable 01..80 in order; write_tag_array and fill_done_d one cycle each, then IDLE.
REQ-036 dcache_miss and icache_miss (addr 16'h0040) rise in the same cycle -> D fill completes first (fill_owner = 1); I fill then issues 0040..004E; fill_done_i follows.
REQ-037 Memory returns with irregular gaps (valid on cycles 4, 6, 7, 10, 11, 12, 15, 16) -> exactly 8 data writes; COMMIT occurs the cycle after the 8th valid.
REQ-038 rst pulsed low in FILL after 3 words -> outputs 0 at once; no tag write; trailing valids ignored; the next miss fills cleanly.
REQ-039 The owner's miss drops in FILL cycle 2 -> the fill still completes with write_tag_array = 1; a stray memory_data_valid in IDLE -> no write_data_array.

Source files
------------

// File: rtl/cache_fill_arbiter_pkg.sv
// Shared cache constants, fill FSM state encoding and small address helpers
// used by the cache fill arbiter and its counters.
package cache_fill_arbiter_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_WORDS = 8;
    localparam int WORD_BYTES  = 2;
    localparam int CNT_W       = $clog2(BLOCK_WORDS);

    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FILL   = 2'b01,
        ST_COMMIT = 2'b10
    } fill_state_e;

    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return addr & BLOCK_MASK;
    endfunction

    // Word addresses stay inside the block because idx is only CNT_W bits wide.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        return base + (ADDR_W'(idx) * ADDR_W'(WORD_BYTES));
    endfunction

    function automatic logic [BLOCK_WORDS-1:0] word_onehot(input logic [CNT_W-1:0] idx);
        return BLOCK_WORDS'(1) << idx;
    endfunction

endpackage

// File: rtl/cache_fill_arbiter_fill_counter.sv
// Word counter for one block fill: synchronous clear has priority over
// enable; tc_o flags the last word index.
module fill_counter
    import cache_fill_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == CNT_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates D-cache and I-cache misses for one memory port and streams an
// 8-word block fill into the owner's arrays, then commits the tag.
module cache_fill_arbiter
    import cache_fill_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dcache_miss,
    input  logic [ADDR_W-1:0]      dcache_miss_addr,
    input  logic                   icache_miss,
    input  logic [ADDR_W-1:0]      icache_miss_addr,
    input  logic                   memory_data_valid,
    input  logic [DATA_W-1:0]      memory_data_out,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_enable,
    output logic                   fsm_busy,
    output logic                   fill_owner,
    output logic [DATA_W-1:0]      fill_data,
    output logic                   write_data_array,
    output logic [BLOCK_WORDS-1:0] word_enable,
    output logic                   write_tag_array,
    output logic                   fill_done_d,
    output logic                   fill_done_i
);

    fill_state_e       state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              issue_done_q, issue_done_d;

    logic              in_fill_s;
    logic              issue_en_s;
    logic              recv_en_s;
    logic [CNT_W-1:0]  issue_cnt_s;
    logic              issue_tc_s;
    logic [CNT_W-1:0]  recv_cnt_s;
    logic              recv_tc_s;

    assign in_fill_s  = (state_q == ST_FILL);
    assign issue_en_s = in_fill_s && !issue_done_q;
    assign recv_en_s  = in_fill_s && memory_data_valid;

    fill_counter u_issue_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (!in_fill_s),
        .en_i    (issue_en_s),
        .count_o (issue_cnt_s),
        .tc_o    (issue_tc_s)
    );

    fill_counter u_recv_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (!in_fill_s),
        .en_i    (recv_en_s),
        .count_o (recv_cnt_s),
        .tc_o    (recv_tc_s)
    );

    // State and fill-context registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            base_q       <= '0;
            issue_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            base_q       <= base_d;
            issue_done_q <= issue_done_d;
        end
    end

    // Next state and grant: D-cache wins ties; completion counts returns, not cycles
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        base_d       = base_q;
        issue_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dcache_miss) begin
                    state_d = ST_FILL;
                    owner_d = 1'b1;
                    base_d  = block_base(dcache_miss_addr);
                end else if (icache_miss) begin
                    state_d = ST_FILL;
                    owner_d = 1'b0;
                    base_d  = block_base(icache_miss_addr);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                issue_done_d = issue_done_q || (issue_en_s && issue_tc_s);
                if (memory_data_valid && recv_tc_s) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode; outputs stay 0 outside the states that drive them
    always_comb begin
        mem_addr         = '0;
        mem_enable       = 1'b0;
        fsm_busy         = 1'b0;
        fill_owner       = 1'b0;
        write_data_array = 1'b0;
        word_enable      = '0;
        write_tag_array  = 1'b0;
        fill_done_d      = 1'b0;
        fill_done_i      = 1'b0;
        case (state_q)
            ST_FILL: begin
                fsm_busy         = 1'b1;
                fill_owner       = owner_q;
                mem_enable       = issue_en_s;
                mem_addr         = issue_en_s ? word_addr(base_q, issue_cnt_s) : '0;
                write_data_array = memory_data_valid;
                word_enable      = memory_data_valid ? word_onehot(recv_cnt_s) : '0;
            end
            ST_COMMIT: begin
                fsm_busy        = 1'b1;
                fill_owner      = owner_q;
                write_tag_array = 1'b1;
                fill_done_d     = owner_q;
                fill_done_i     = !owner_q;
            end
            default: begin
                mem_enable = 1'b0;
            end
        endcase
    end

    assign fill_data = memory_data_out;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: queues of expected issues, writes
// and commits are filled when a miss is raised and drained as the DUT acts.
module tb_cache_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        dcache_miss;
    logic [15:0] dcache_miss_addr;
    logic        icache_miss;
    logic [15:0] icache_miss_addr;
    logic        memory_data_valid;
    logic [15:0] memory_data_out;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        fsm_busy;
    logic        fill_owner;
    logic [15:0] fill_data;
    logic        write_data_array;
    logic [7:0]  word_enable;
    logic        write_tag_array;
    logic        fill_done_d;
    logic        fill_done_i;

    cache_fill_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .dcache_miss       (dcache_miss),
        .dcache_miss_addr  (dcache_miss_addr),
        .icache_miss       (icache_miss),
        .icache_miss_addr  (icache_miss_addr),
        .memory_data_valid (memory_data_valid),
        .memory_data_out   (memory_data_out),
        .mem_addr          (mem_addr),
        .mem_enable        (mem_enable),
        .fsm_busy          (fsm_busy),
        .fill_owner        (fill_owner),
        .fill_data         (fill_data),
        .write_data_array  (write_data_array),
        .word_enable       (word_enable),
        .write_tag_array   (write_tag_array),
        .fill_done_d       (fill_done_d),
        .fill_done_i       (fill_done_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;

    typedef struct {
        logic [7:0]  we;
        logic [15:0] data;
        logic        owner;
    } wr_t;

    ret_t        ret_q[$];
    logic [15:0] exp_addr_q[$];
    wr_t         exp_wr_q[$];
    logic        exp_commit_q[$];

    int cyc;
    int n_checks;
    int n_pass;
    int n_fail;
    int n_writes;
    int n_commits;
    int last_commit_cyc;
    bit auto_mem;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_addr"},         32'(mem_addr),         32'd0);
        check({tag, "_mem_enable"},       32'(mem_enable),       32'd0);
        check({tag, "_fsm_busy"},         32'(fsm_busy),         32'd0);
        check({tag, "_fill_owner"},       32'(fill_owner),       32'd0);
        check({tag, "_write_data_array"}, 32'(write_data_array), 32'd0);
        check({tag, "_word_enable"},      32'(word_enable),      32'd0);
        check({tag, "_write_tag_array"},  32'(write_tag_array),  32'd0);
        check({tag, "_fill_done_d"},      32'(fill_done_d),      32'd0);
        check({tag, "_fill_done_i"},      32'(fill_done_i),      32'd0);
    endtask

    // Expected block: 8 ascending word addresses, one-hot writes, one commit.
    task automatic expect_block(input logic [15:0] base, input logic owner);
        wr_t w;
        for (int k = 0; k < 8; k++) begin
            exp_addr_q.push_back(base + 16'(2 * k));
            w.we    = 8'b0000_0001 << k;
            w.data  = (base + 16'(2 * k)) ^ 16'hA5A5;
            w.owner = owner;
            exp_wr_q.push_back(w);
        end
        exp_commit_q.push_back(owner);
    endtask

    // One clock cycle: apply memory return, check outputs mid-cycle, advance.
    task automatic tick();
        wr_t         w;
        ret_t        r;
        logic [15:0] a;
        logic        o;
        if (auto_mem) begin
            if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
                r = ret_q.pop_front();
                memory_data_valid = 1'b1;
                memory_data_out   = r.data;
            end else begin
                memory_data_valid = 1'b0;
                memory_data_out   = 16'h0000;
            end
        end
        #1;
        if (mem_enable) begin
            if (exp_addr_q.size() == 0) begin
                check("stray_issue", 32'(mem_enable), 32'd0);
            end else begin
                a = exp_addr_q.pop_front();
                check("mem_addr", 32'(mem_addr), 32'(a));
            end
            if (auto_mem) begin
                r.due  = cyc + 3;
                r.data = mem_addr ^ 16'hA5A5;
                ret_q.push_back(r);
            end
        end else begin
            check("mem_addr_when_disabled", 32'(mem_addr), 32'd0);
        end
        if (write_data_array) begin
            n_writes++;
            if (exp_wr_q.size() == 0) begin
                check("stray_write", 32'(write_data_array), 32'd0);
            end else begin
                w = exp_wr_q.pop_front();
                check("word_enable", 32'(word_enable), 32'(w.we));
                check("fill_data",   32'(fill_data),   32'(w.data));
                check("fill_owner",  32'(fill_owner),  32'(w.owner));
            end
        end
        if (write_tag_array) begin
            n_commits++;
            last_commit_cyc = cyc;
            if (exp_commit_q.size() == 0) begin
                check("stray_commit", 32'(write_tag_array), 32'd0);
            end else begin
                o = exp_commit_q.pop_front();
                check("fill_done_d", 32'(fill_done_d), 32'(o));
                check("fill_done_i", 32'(fill_done_i), 32'(!o));
                check("commit_busy", 32'(fsm_busy),    32'd1);
            end
            if (fill_done_d) dcache_miss = 1'b0;
            if (fill_done_i) icache_miss = 1'b0;
        end else begin
            check("done_without_commit", 32'({fill_done_d, fill_done_i}), 32'd0);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_commits(input int target, input int budget);
        int i = 0;
        while (n_commits < target && i < budget) begin
            tick();
            i++;
        end
        check("commit_timeout", 32'(n_commits), 32'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g;
        int          w0;
        int          c0;
        int          k;
        int          i;
        logic [31:0] vmask;
        wr_t         w;

        n_checks = 0; n_pass = 0; n_fail = 0; n_writes = 0; n_commits = 0;
        cyc = 0; last_commit_cyc = -1; auto_mem = 1'b1;
        rst = 1'b0;
        dcache_miss = 1'b0; dcache_miss_addr = 16'h0000;
        icache_miss = 1'b0; icache_miss_addr = 16'h0000;
        memory_data_valid = 1'b0; memory_data_out = 16'h0000;

        #2;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check("idle_after_reset", 32'(fsm_busy), 32'd0);

        // Single D-cache fill, 4-cycle memory
        expect_block(16'h1230, 1'b1);
        dcache_miss = 1'b1; dcache_miss_addr = 16'h1236;
        g = cyc; w0 = n_writes;
        run_commits(1, 40);
        check("t1_commit_cycle", 32'(last_commit_cyc), 32'(g + 12));
        check("t1_writes", 32'(n_writes - w0), 32'd8);
        check("t1_idle_after_commit", 32'(fsm_busy), 32'd0);
        tick();

        // Simultaneous misses: D first, I granted right after
        expect_block(16'h2100, 1'b1);
        expect_block(16'h0040, 1'b0);
        dcache_miss = 1'b1; dcache_miss_addr = 16'h210C;
        icache_miss = 1'b1; icache_miss_addr = 16'h0040;
        g = cyc; c0 = n_commits;
        run_commits(c0 + 1, 40);
        check("t2_d_commit_cycle", 32'(last_commit_cyc), 32'(g + 12));
        run_commits(c0 + 2, 40);
        check("t2_i_commit_cycle", 32'(last_commit_cyc), 32'(g + 25));
        tick();

        // Irregular return gaps, plus a stray valid during COMMIT
        auto_mem = 1'b0;
        memory_data_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            exp_addr_q.push_back(16'h3000 + 16'(2 * j));
            w.we = 8'b0000_0001 << j; w.data = 16'hC000 + 16'(j); w.owner = 1'b1;
            exp_wr_q.push_back(w);
        end
        exp_commit_q.push_back(1'b1);
        vmask = (32'd1 << 4) | (32'd1 << 6) | (32'd1 << 7) | (32'd1 << 10) |
                (32'd1 << 11) | (32'd1 << 12) | (32'd1 << 15) | (32'd1 << 16);
        dcache_miss = 1'b1; dcache_miss_addr = 16'h300F;
        g = cyc; w0 = n_writes; k = 0;
        for (int r = 0; r < 19; r++) begin
            if (vmask[r]) begin
                memory_data_valid = 1'b1;
                memory_data_out   = 16'hC000 + 16'(k);
                k++;
            end else if (r == 17) begin
                memory_data_valid = 1'b1;
                memory_data_out   = 16'hDEAD;
            end else begin
                memory_data_valid = 1'b0;
                memory_data_out   = 16'h0000;
            end
            tick();
        end
        memory_data_valid = 1'b0;
        check("t3_commit_cycle", 32'(last_commit_cyc), 32'(g + 17));
        check("t3_writes", 32'(n_writes - w0), 32'd8);

        // Owner drops its miss in FILL cycle 2; fill still completes
        auto_mem = 1'b1;
        expect_block(16'h00A0, 1'b0);
        icache_miss = 1'b1; icache_miss_addr = 16'h00A3;
        w0 = n_writes; c0 = n_commits;
        tick();
        tick();
        icache_miss = 1'b0;
        run_commits(c0 + 1, 40);
        check("t4_writes", 32'(n_writes - w0), 32'd8);

        // Stray valid while IDLE
        auto_mem = 1'b0;
        memory_data_valid = 1'b1; memory_data_out = 16'hBEEF;
        w0 = n_writes;
        tick();
        tick();
        memory_data_valid = 1'b0;
        check("t4_stray_idle_valid", 32'(n_writes - w0), 32'd0);
        auto_mem = 1'b1;

        // Reset after 3 words; trailing returns must be ignored
        expect_block(16'h4440, 1'b1);
        dcache_miss = 1'b1; dcache_miss_addr = 16'h4447;
        w0 = n_writes; i = 0;
        while (n_writes - w0 < 3 && i < 30) begin
            tick();
            i++;
        end
        check("t5_three_words", 32'(n_writes - w0), 32'd3);
        rst = 1'b0;
        #1;
        check_zero("rst_mid_fill");
        exp_addr_q.delete();
        exp_wr_q.delete();
        exp_commit_q.delete();
        dcache_miss = 1'b0;
        c0 = n_commits;
        #1;
        rst = 1'b1;
        for (int j = 0; j < 12; j++) tick();
        check("t5_no_commit", 32'(n_commits), 32'(c0));
        check("t5_no_trailing_writes", 32'(n_writes - w0), 32'd3);

        // Clean fill after reset
        expect_block(16'h4440, 1'b1);
        dcache_miss = 1'b1; dcache_miss_addr = 16'h444E;
        g = cyc; w0 = n_writes;
        run_commits(c0 + 1, 40);
        check("t5_clean_commit_cycle", 32'(last_commit_cyc), 32'(g + 12));
        check("t5_clean_writes", 32'(n_writes - w0), 32'd8);
        tick();

        check("addr_queue_drained",   32'(exp_addr_q.size()),   32'd0);
        check("write_queue_drained",  32'(exp_wr_q.size()),     32'd0);
        check("commit_queue_drained", 32'(exp_commit_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
